// File: rtl/defines.sv
// Shared pipeline encodings for the 5-stage RISC-V core.
// Zero in every enum is the "do nothing" value, so an all-zero bundle is a NOP.
package defines;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC4  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        FW_NONE    = 2'd0,
        FW_MEM_ALU = 2'd1,
        FW_WB_DATA = 2'd2,
        FW_RSVD    = 2'd3
    } fw_sel_e;

    typedef enum logic [2:0] {
        ALUOP_NONE        = 3'd0,
        ALUOP_RTYPE       = 3'd1,
        ALUOP_ITYPE_ARITH = 3'd2,
        ALUOP_LOAD        = 3'd3,
        ALUOP_STORE       = 3'd4,
        ALUOP_BRANCH      = 3'd5,
        ALUOP_LUI         = 3'd6,
        ALUOP_AUIPC       = 3'd7
    } alu_op_e;

endpackage

// File: rtl/id_to_ex_if.sv
// ID/EX bundle: decode drives the ID_* side, the pipeline register drives EX_*.
// There is no handshake: the register loads unconditionally every edge.
interface id_to_ex_if;
    import defines::*;

    wb_sel_e                 ID_WBSel_i,       EX_WBSel_o;
    fw_sel_e                 ID_forwardA_i,    EX_forwardA_o;
    fw_sel_e                 ID_forwardB_i,    EX_forwardB_o;
    logic                    ID_MemRead_i,     EX_MemRead_o;
    logic                    ID_MemWrite_i,    EX_MemWrite_o;
    logic                    ID_RegWrite_i,    EX_RegWrite_o;
    alu_op_e                 ID_ALUOp_i,       EX_ALUOp_o;
    logic                    ID_ALUOpSrc1_i,   EX_ALUOpSrc1_o;
    logic                    ID_ALUOpSrc2_i,   EX_ALUOpSrc2_o;
    logic [DATA_WIDTH-1:0]   ID_instruction_i, EX_instruction_o;
    logic [DATA_WIDTH-1:0]   ID_rd_data1_i,    EX_rd_data1_o;
    logic [DATA_WIDTH-1:0]   ID_rd_data2_i,    EX_rd_data2_o;
    logic [DATA_WIDTH-1:0]   ID_imm_i,         EX_imm_o;
    logic [DATA_WIDTH-1:0]   ID_pc_i,          EX_pc_o;
    logic [DATA_WIDTH-1:0]   ID_pc_plus4_i,    EX_pc_plus4_o;

    modport master (
        output ID_WBSel_i, ID_forwardA_i, ID_forwardB_i, ID_MemRead_i, ID_MemWrite_i,
               ID_RegWrite_i, ID_ALUOp_i, ID_ALUOpSrc1_i, ID_ALUOpSrc2_i, ID_instruction_i,
               ID_rd_data1_i, ID_rd_data2_i, ID_imm_i, ID_pc_i, ID_pc_plus4_i,
        input  EX_WBSel_o, EX_forwardA_o, EX_forwardB_o, EX_MemRead_o, EX_MemWrite_o,
               EX_RegWrite_o, EX_ALUOp_o, EX_ALUOpSrc1_o, EX_ALUOpSrc2_o, EX_instruction_o,
               EX_rd_data1_o, EX_rd_data2_o, EX_imm_o, EX_pc_o, EX_pc_plus4_o
    );

    modport slave (
        input  ID_WBSel_i, ID_forwardA_i, ID_forwardB_i, ID_MemRead_i, ID_MemWrite_i,
               ID_RegWrite_i, ID_ALUOp_i, ID_ALUOpSrc1_i, ID_ALUOpSrc2_i, ID_instruction_i,
               ID_rd_data1_i, ID_rd_data2_i, ID_imm_i, ID_pc_i, ID_pc_plus4_i,
        output EX_WBSel_o, EX_forwardA_o, EX_forwardB_o, EX_MemRead_o, EX_MemWrite_o,
               EX_RegWrite_o, EX_ALUOp_o, EX_ALUOpSrc1_o, EX_ALUOpSrc2_o, EX_instruction_o,
               EX_rd_data1_o, EX_rd_data2_o, EX_imm_o, EX_pc_o, EX_pc_plus4_o
    );

endinterface

// File: rtl/id_to_ex.sv
// ID/EX pipeline register. Loads the decode bundle every edge; reset or flush
// replaces it with the all-zero NOP bundle so nothing writes memory or the register file.
module id_to_ex
    import defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    id_to_ex_if.slave   bus
);

    typedef struct packed {
        wb_sel_e               wb_sel;
        fw_sel_e               forward_a;
        fw_sel_e               forward_b;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        alu_op_e               alu_op;
        logic                  alu_src1;
        logic                  alu_src2;
        logic [DATA_WIDTH-1:0] instruction;
        logic [DATA_WIDTH-1:0] rd_data1;
        logic [DATA_WIDTH-1:0] rd_data2;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
    } ex_bundle_t;

    ex_bundle_t bundle_d;
    ex_bundle_t bundle_q;

    // Flush discards the decode bundle; the zero default is the bubble.
    always_comb begin
        bundle_d = '0;
        if (!flush_i) begin
            bundle_d.wb_sel      = bus.ID_WBSel_i;
            bundle_d.forward_a   = bus.ID_forwardA_i;
            bundle_d.forward_b   = bus.ID_forwardB_i;
            bundle_d.mem_read    = bus.ID_MemRead_i;
            bundle_d.mem_write   = bus.ID_MemWrite_i;
            bundle_d.reg_write   = bus.ID_RegWrite_i;
            bundle_d.alu_op      = bus.ID_ALUOp_i;
            bundle_d.alu_src1    = bus.ID_ALUOpSrc1_i;
            bundle_d.alu_src2    = bus.ID_ALUOpSrc2_i;
            bundle_d.instruction = bus.ID_instruction_i;
            bundle_d.rd_data1    = bus.ID_rd_data1_i;
            bundle_d.rd_data2    = bus.ID_rd_data2_i;
            bundle_d.imm         = bus.ID_imm_i;
            bundle_d.pc          = bus.ID_pc_i;
            bundle_d.pc_plus4    = bus.ID_pc_plus4_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign bus.EX_WBSel_o       = bundle_q.wb_sel;
    assign bus.EX_forwardA_o    = bundle_q.forward_a;
    assign bus.EX_forwardB_o    = bundle_q.forward_b;
    assign bus.EX_MemRead_o     = bundle_q.mem_read;
    assign bus.EX_MemWrite_o    = bundle_q.mem_write;
    assign bus.EX_RegWrite_o    = bundle_q.reg_write;
    assign bus.EX_ALUOp_o       = bundle_q.alu_op;
    assign bus.EX_ALUOpSrc1_o   = bundle_q.alu_src1;
    assign bus.EX_ALUOpSrc2_o   = bundle_q.alu_src2;
    assign bus.EX_instruction_o = bundle_q.instruction;
    assign bus.EX_rd_data1_o    = bundle_q.rd_data1;
    assign bus.EX_rd_data2_o    = bundle_q.rd_data2;
    assign bus.EX_imm_o         = bundle_q.imm;
    assign bus.EX_pc_o          = bundle_q.pc;
    assign bus.EX_pc_plus4_o    = bundle_q.pc_plus4;

endmodule

// File: tb/tb_id_to_ex.sv
// Directed bench for the ID/EX register: reset, pass-through, flush, priority and latency.
module tb_id_to_ex;
    import defines::*;

    typedef struct packed {
        wb_sel_e     wb;
        fw_sel_e     fa;
        fw_sel_e     fb;
        logic        mr;
        logic        mw;
        logic        rw;
        alu_op_e     op;
        logic        s1;
        logic        s2;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    logic clk;
    logic rst;
    logic flush_i;
    int   checks;
    int   errors;

    id_to_ex_if bus ();

    id_to_ex dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        bus.ID_WBSel_i       = v.wb;
        bus.ID_forwardA_i    = v.fa;
        bus.ID_forwardB_i    = v.fb;
        bus.ID_MemRead_i     = v.mr;
        bus.ID_MemWrite_i    = v.mw;
        bus.ID_RegWrite_i    = v.rw;
        bus.ID_ALUOp_i       = v.op;
        bus.ID_ALUOpSrc1_i   = v.s1;
        bus.ID_ALUOpSrc2_i   = v.s2;
        bus.ID_instruction_i = v.instr;
        bus.ID_rd_data1_i    = v.rd1;
        bus.ID_rd_data2_i    = v.rd2;
        bus.ID_imm_i         = v.imm;
        bus.ID_pc_i          = v.pc;
        bus.ID_pc_plus4_i    = v.pc4;
    endtask

    function automatic vec_t sample();
        vec_t v;
        v.wb    = bus.EX_WBSel_o;
        v.fa    = bus.EX_forwardA_o;
        v.fb    = bus.EX_forwardB_o;
        v.mr    = bus.EX_MemRead_o;
        v.mw    = bus.EX_MemWrite_o;
        v.rw    = bus.EX_RegWrite_o;
        v.op    = bus.EX_ALUOp_o;
        v.s1    = bus.EX_ALUOpSrc1_o;
        v.s2    = bus.EX_ALUOpSrc2_o;
        v.instr = bus.EX_instruction_o;
        v.rd1   = bus.EX_rd_data1_o;
        v.rd2   = bus.EX_rd_data2_o;
        v.imm   = bus.EX_imm_o;
        v.pc    = bus.EX_pc_o;
        v.pc4   = bus.EX_pc_plus4_o;
        return v;
    endfunction

    task automatic check(input string tag, input vec_t exp);
        vec_t got;
        got = sample();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t cleared;
    vec_t pass_v;
    vec_t flush_v;
    vec_t lat_v;
    vec_t prev_v;

    initial begin
        checks  = 0;
        errors  = 0;
        cleared = '0;

        pass_v = '{wb: WB_ALU, fa: FW_MEM_ALU, fb: FW_WB_DATA, mr: 1'b1, mw: 1'b1,
                   rw: 1'b1, op: ALUOP_RTYPE, s1: 1'b1, s2: 1'b1,
                   instr: 32'hABCDEF01, rd1: 32'h11112222, rd2: 32'h33334444,
                   imm: 32'h55556666, pc: 32'h00001000, pc4: 32'h00001004};
        flush_v = '{wb: WB_MEM, fa: FW_WB_DATA, fb: FW_MEM_ALU, mr: 1'b1, mw: 1'b0,
                    rw: 1'b1, op: ALUOP_ITYPE_ARITH, s1: 1'b0, s2: 1'b1,
                    instr: 32'h00A28293, rd1: 32'hDEADBEEF, rd2: 32'hCAFEF00D,
                    imm: 32'hFFFFF800, pc: 32'h00002000, pc4: 32'h00002004};

        // Reset held for two edges with all inputs zero.
        rst = 1'b1;
        flush_i = 1'b0;
        drive(cleared);
        step();
        check("reset_edge1", cleared);
        step();
        check("reset_edge2", cleared);

        // Pass-through.
        rst = 1'b0;
        drive(pass_v);
        step();
        check("pass_through", pass_v);

        // Flush discards nonzero inputs.
        flush_i = 1'b1;
        drive(flush_v);
        step();
        check("flush_bubble", cleared);

        // Flush release loads on the next edge.
        flush_i = 1'b0;
        drive(pass_v);
        step();
        check("flush_release", pass_v);

        // Back-to-back flushes, then release with a different bundle.
        flush_i = 1'b1;
        drive(flush_v);
        step();
        check("flush_b2b_1", cleared);
        step();
        check("flush_b2b_2", cleared);
        flush_i = 1'b0;
        step();
        check("flush_b2b_release", flush_v);

        // rst and flush raised mid-cycle: no effect until the edge.
        rst = 1'b1;
        flush_i = 1'b1;
        drive(pass_v);
        #3;
        check("midcycle_hold", flush_v);
        step();
        check("rst_and_flush", cleared);

        // Reload, then reset alone with nonzero inputs.
        rst = 1'b0;
        flush_i = 1'b0;
        step();
        check("reload_after_rst", pass_v);
        rst = 1'b1;
        drive(flush_v);
        step();
        check("rst_only", cleared);

        // Latency: new bundle every cycle, outputs must lag by exactly one edge.
        rst = 1'b0;
        prev_v = cleared;
        for (int i = 0; i < 8; i++) begin
            lat_v = '{wb: wb_sel_e'(2'(i)), fa: fw_sel_e'(2'(i + 1)), fb: fw_sel_e'(2'(i + 2)),
                      mr: i[0], mw: i[1], rw: i[2], op: alu_op_e'(3'(7 - i)),
                      s1: ~i[0], s2: ~i[1],
                      instr: 32'h01010101 * i, rd1: 32'h10000000 + i, rd2: 32'hF0000000 - i,
                      imm: 32'h00000100 << i, pc: 32'(4 * i), pc4: 32'(4 * i + 4)};
            drive(lat_v);
            #2;
            check($sformatf("latency_hold_%0d", i), prev_v);
            step();
            check($sformatf("latency_load_%0d", i), lat_v);
            prev_v = lat_v;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_to_ex.md
# id_to_ex

ID/EX pipeline register of the 5-stage RISC-V core. Captures the decode-stage control bundle and datapath operands on each rising clock edge and presents them to the execute stage one cycle later. Supports synchronous reset and a synchronous flush that inserts a bubble (NOP) into EX.

## Interface
Parameters (from `defines` package):
- DATA_WIDTH, 32, width of instruction, operand, immediate and PC fields
- wb_sel_e, 2-bit enum, write-back select; WB_NONE = 0, plus WB_ALU, WB_MEM and the remaining package encodings
- fw_sel_e, 2-bit enum, forwarding select; FW_NONE = 0, plus FW_MEM_ALU and FW_WB_DATA
- alu_op_e, 3-bit enum, ALU op class; ALUOP_NONE = 0, plus ALUOP_RTYPE, ALUOP_ITYPE_ARITH, etc.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- flush_i  in  1  synchronous bubble insert
- ID_WBSel_i / EX_WBSel_o  in/out  wb_sel_e  write-back source
- ID_forwardA_i / EX_forwardA_o  in/out  fw_sel_e  operand-A forward select
- ID_forwardB_i / EX_forwardB_o  in/out  fw_sel_e  operand-B forward select
- ID_MemRead_i / EX_MemRead_o  in/out  1  load enable
- ID_MemWrite_i / EX_MemWrite_o  in/out  1  store enable
- ID_RegWrite_i / EX_RegWrite_o  in/out  1  register-file write enable
- ID_ALUOp_i / EX_ALUOp_o  in/out  alu_op_e  ALU op class
- ID_ALUOpSrc1_i / EX_ALUOpSrc1_o  in/out  1  ALU operand-1 source select
- ID_ALUOpSrc2_i / EX_ALUOpSrc2_o  in/out  1  ALU operand-2 source select
- ID_instruction_i / EX_instruction_o  in/out  DATA_WIDTH  raw instruction
- ID_rd_data1_i / EX_rd_data1_o  in/out  DATA_WIDTH  rs1 read data
- ID_rd_data2_i / EX_rd_data2_o  in/out  DATA_WIDTH  rs2 read data
- ID_imm_i / EX_imm_o  in/out  DATA_WIDTH  sign-extended immediate
- ID_pc_i / EX_pc_o  in/out  DATA_WIDTH  instruction PC
- ID_pc_plus4_i / EX_pc_plus4_o  in/out  DATA_WIDTH  PC + 4

## Operation
- Each EX_*_o is driven directly from a dedicated flop; no combinational path from any input to any output.
- Per rising edge, priority order:
  1. rst = 1: all outputs cleared.
  2. else flush_i = 1: all outputs cleared (bubble), input values discarded.
  3. else: every EX_*_o <= corresponding ID_*_i, bit-exact.
- Cleared state: EX_WBSel_o = WB_NONE, EX_forwardA_o = EX_forwardB_o = FW_NONE, EX_ALUOp_o = ALUOP_NONE, all 1-bit controls = 0, all DATA_WIDTH fields = 0. The cleared bundle is a NOP: no memory access, no register write.
- No stall/enable input: the register loads every non-reset, non-flush cycle.
- No field is decoded, modified or checked; values pass through unchanged.

## Timing
- Latency: exactly 1 cycle, ID inputs sampled at edge N and visible on EX outputs after edge N.
- Reset and flush act only at a clock edge. Asserting rst or flush_i between edges does not change outputs until the next rising edge.
- Reset value of every output is the cleared state above; it holds for every edge while rst = 1.
- rst and flush_i both high: reset wins (same cleared result).
- flush_i for one cycle clears EX for exactly that cycle. The next edge with flush_i = 0 loads the current ID inputs normally.
- Back-to-back flushes keep EX cleared for each flushed edge.
- Outputs are undefined (X) between power-up and the first reset edge; no initial values are required.

## Test plan
- Reset: rst = 1 for 2 edges with all inputs 0 -> every output in cleared state (WB_NONE/FW_NONE/ALUOP_NONE, zeros).
- Pass-through: rst = 0, inputs WB_ALU, FW_MEM_ALU, FW_WB_DATA, MemRead/MemWrite/RegWrite/Src1/Src2 = 1, ALUOP_RTYPE, instr 0xABCDEF01, rd1 0x11112222, rd2 0x33334444, imm 0x55556666, pc 0x00001000, pc4 0x00001004 -> identical values on EX outputs after one edge.
- Flush: from the loaded state, flush_i = 1 with inputs WB_MEM, ALUOP_ITYPE_ARITH and nonzero data -> after the edge, all outputs are in the cleared state and none of the inputs appear.
- Flush release: flush_i back to 0 with inputs of the pass-through case -> loaded exactly on the next edge.
- Priority: rst = 1 and flush_i = 1 with nonzero inputs -> cleared; rst = 1 with flush_i = 0 and nonzero inputs -> cleared.
- Latency: change ID inputs every cycle (pc = 0x0, 0x4, 0x8, …) -> EX_pc_o lags by exactly one edge, with no glitch from input changes made mid-cycle.
